arm_mc_controller: RTL and testbench
====================================

Name: arm_mc_controller

Overview:
- Multicycle control unit for the ARM-subset processor: replaces the single-cycle decode with a state machine that sequences one shared instruction/data memory.
- Adds memory wait-state handshake, on-chip NZCV flag register, full condition-code evaluation and a bus-timeout trap.
- Sits beside the multicycle datapath inside the processor top; drives every datapath mux/enable from Instr[31:12], ALUFlags and MemReady.

Parameters:
- ALUCTRL_W, 3, ALUControl width (>=3); upper bits beyond [2:0] driven 0.
- MAX_WAIT, 0, max MemReady wait cycles per access; 0 = unlimited (no timeout).
- WAIT_CNT_W, 8, wait counter width; MAX_WAIT < 2**WAIT_CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  20  Instr[31:12] from instruction register.
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
- MemReady  in  1  memory completes access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write qualifier for MemReq.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC.
- RegWrite  out  1  register file write.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- ALUSrcA  out  1  0=A reg, 1=PC.
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult.
- ImmSrc  out  2  = Instr[27:26].
- RegSrc  out  2  [0]=1 branch (Rn=R15), [1]=1 STR (Rm=Rd).
- ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
- Flags  out  4  registered NZCV.
- BusErr  out  1  sticky timeout indicator.
- State  out  4  current state encoding (debug).

Behaviour:
- Reset (reset=0): state=FETCH, Flags=0000, wait counter=0, BusErr=0; all enable outputs (MemReq, MemWrite, IRWrite, PCWrite, RegWrite) forced 0 while reset low. Async assert, synchronous-to-clk release.
- Decode: Op=Instr[27:26] (00 DP, 01 LDR/STR with L=Instr[20], 10 B, 11 undefined); I=Instr[25]; cmd=Instr[24:21]; S=Instr[20]; Rd=Instr[15:12].
- Supported DP cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP (SUB, no reg write, requires S=1). Other cmd treated as undefined.
- CondEx: combinational from Flags and Instr[31:28]; all 14 ARM conditions plus 1110 always; 1111 never.
- States 0..10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, HALT.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Holds until MemReady=1; on that cycle IRWrite=1, PCWrite=1, -> DECODE. IRWrite/PCWrite never asserted while waiting.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD (PC+8 to ALUOut). Next: !CondEx or undefined -> FETCH; mem -> MEMADR; DP I=0 -> EXECR; I=1 -> EXECI; B -> BRANCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; L=1 -> MEMREAD else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1; hold until MemReady, then -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15; -> FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1 (level, every waiting cycle); MemReady -> FETCH.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALUControl per cmd; if S=1 Flags<=ALUFlags at clock edge. CMP -> FETCH, else -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; PCWrite=1 if Rd=15; -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1; -> FETCH.
- Timeout (MAX_WAIT>0): counter clears on entering any MemReq state and on MemReady; increments each MemReady=0 wait cycle; when count reaches MAX_WAIT with MemReady=0 -> HALT, BusErr=1. HALT: all enables 0, exits only by reset. MAX_WAIT=0: never times out.
- MemReady ignored outside MemReq states.
- Latency (zero wait): B 3, DP/STR 4, LDR 5 cycles.

Test Plan:
- Reset low mid-MEMREAD -> State=0, Flags=0000, all enables 0 immediately; after release FETCH, MemReq=1.
- ADD R1,R2,#5 (E2821005), MemReady=1 always -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in ALUWB; Flags unchanged.
- SUBS with ALUFlags=0100 then BEQ (0A000002) -> Flags=0100, BRANCH reached, PCWrite=1; BNE (1A000002) -> DECODE->FETCH, no PCWrite.
- LDR (E5921004), MemReady low 3 cycles in FETCH and MEMREAD -> states hold, IRWrite pulses once, total 11 cycles, RegWrite once in MEMWB.
- STR (E5821000) -> MemWrite=1 with MemReq throughout MEMWRITE, RegSrc=10, no RegWrite.
- MAX_WAIT=4, MemReady held 0 in FETCH -> HALT after wait count reaches 4, BusErr=1 sticky, enables 0 until reset.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multicycle ARM-subset control FSM: sequences shared memory, datapath muxes, NZCV flags, bus timeout.
// Latency: B 3, DP/STR 4, LDR 5 cycles at zero wait; each MemReady=0 cycle adds one cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold MemReq until MemReady; MAX_WAIT>0 traps to HALT on timeout.
module arm_mc_controller #(
    parameter int ALUCTRL_W  = 3,
    parameter int MAX_WAIT   = 0,
    parameter int WAIT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic                 BusErr,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_flags;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_buserr;

    // Instruction fields; Instr[k] of the full word sits at index k-12 here.
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [3:0] w_rd;
    logic       w_unused_rn;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_i         = Instr[13];
    assign w_cmd       = Instr[12:9];
    assign w_s         = Instr[8];
    assign w_rd        = Instr[3:0];
    assign w_unused_rn = ^Instr[7:4];

    logic [2:0] w_dp_alu;
    logic       w_dp_ok;
    logic       w_is_cmp;
    logic       w_undef;

    // DP command decode; CMP without S is not a legal encoding in this subset.
    always_comb begin
        w_dp_alu = 3'b000;
        w_dp_ok  = 1'b1;
        w_is_cmp = 1'b0;
        case (w_cmd)
            4'b0100: w_dp_alu = 3'b000;
            4'b0010: w_dp_alu = 3'b001;
            4'b0000: w_dp_alu = 3'b010;
            4'b1100: w_dp_alu = 3'b011;
            4'b0001: w_dp_alu = 3'b100;
            4'b1010: begin
                w_dp_alu = 3'b001;
                w_is_cmp = 1'b1;
                w_dp_ok  = w_s;
            end
            default: w_dp_ok = 1'b0;
        endcase
    end

    assign w_undef = (w_op == 2'b11) || ((w_op == 2'b00) && !w_dp_ok);

    logic w_n, w_z, w_c, w_v;
    logic w_condex;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition-code evaluation against the registered flags.
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = !w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = !w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = !w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = !w_v;
            4'b1000: w_condex = w_c && !w_z;
            4'b1001: w_condex = !w_c || w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = !w_z && (w_n == w_v);
            4'b1101: w_condex = w_z || (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    logic w_mem_state;
    logic w_timeout;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    // The access may wait MAX_WAIT cycles; still not ready once the count has reached it traps.
    assign w_timeout   = (MAX_WAIT != 0) && w_mem_state && !MemReady &&
                         (r_wait_cnt == WAIT_CNT_W'(MAX_WAIT));

    logic       w_memreq, w_memwrite, w_irwrite, w_pcwrite, w_regwrite;
    logic       w_flag_we;
    logic [2:0] w_alu3;

    // Next-state and per-state datapath controls.
    always_comb begin
        w_next     = r_state;
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_flag_we  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        w_alu3     = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (!w_condex || w_undef) w_next = S_FETCH;
                else if (w_op == 2'b01)   w_next = S_MEMADR;
                else if (w_op == 2'b10)   w_next = S_BRANCH;
                else if (w_i)             w_next = S_EXECI;
                else                      w_next = S_EXECR;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = w_s ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_memreq = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady)       w_next = S_MEMWB;
                else if (w_timeout) w_next = S_HALT;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_pcwrite  = (w_rd == 4'hF);
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                AdrSrc     = 1'b1;
                if (MemReady)       w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu3    = w_dp_alu;
                w_flag_we = w_s;
                w_next    = w_is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_pcwrite  = (w_rd == 4'hF);
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // NZCV register, loaded from the ALU in execute when S is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_flags <= 4'b0000;
        else if (w_flag_we) r_flags <= ALUFlags;
    end

    // Wait counter: restarts on any state change or completed access, counts stalled access cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      r_wait_cnt <= '0;
        else if (MemReady || (r_state != w_next))        r_wait_cnt <= '0;
        else if (w_mem_state && (MAX_WAIT != 0))         r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    // Sticky bus-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_buserr <= 1'b0;
        else if (w_timeout) r_buserr <= 1'b1;
    end

    // Enables are gated by reset so nothing fires while the core is held.
    assign MemReq     = w_memreq   & reset;
    assign MemWrite   = w_memwrite & reset;
    assign IRWrite    = w_irwrite  & reset;
    assign PCWrite    = w_pcwrite  & reset;
    assign RegWrite   = w_regwrite & reset;
    assign ImmSrc     = w_op;
    assign RegSrc     = {(w_op == 2'b01) && !w_s, (w_op == 2'b10)};
    assign ALUControl = ALUCTRL_W'(w_alu3);
    assign Flags      = r_flags;
    assign BusErr     = r_buserr;
    assign State      = r_state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: instruction flows, wait states, reset and timeout trap.
// One instance uses MAX_WAIT=4 (timeout), a second uses MAX_WAIT=0 (never traps).
// Inputs change 1 time unit after the rising edge; outputs are checked shortly after that.
module tb_arm_mc_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;

    logic       MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, BusErr;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags, State;

    logic       z_MemReq, z_MemWrite, z_IRWrite, z_PCWrite, z_RegWrite, z_AdrSrc, z_ALUSrcA, z_BusErr;
    logic [1:0] z_ALUSrcB, z_ResultSrc, z_ImmSrc, z_RegSrc;
    logic [2:0] z_ALUControl;
    logic [3:0] z_Flags, z_State;

    logic [4:0] w_en;
    assign w_en = {MemReq, MemWrite, IRWrite, PCWrite, RegWrite};

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int ir_cnt = 0;
    int rw_cnt = 0;

    arm_mc_controller #(.ALUCTRL_W(3), .MAX_WAIT(4), .WAIT_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .BusErr(BusErr), .State(State)
    );

    arm_mc_controller #(.ALUCTRL_W(3), .MAX_WAIT(0), .WAIT_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .MemReq(z_MemReq), .MemWrite(z_MemWrite), .IRWrite(z_IRWrite), .PCWrite(z_PCWrite),
        .RegWrite(z_RegWrite), .AdrSrc(z_AdrSrc), .ALUSrcA(z_ALUSrcA), .ALUSrcB(z_ALUSrcB),
        .ResultSrc(z_ResultSrc), .ImmSrc(z_ImmSrc), .RegSrc(z_RegSrc), .ALUControl(z_ALUControl),
        .Flags(z_Flags), .BusErr(z_BusErr), .State(z_State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input string tag, input logic [3:0] st, input logic [4:0] en);
        #1;
        chk({tag, " state"}, 32'(State), 32'(st));
        chk({tag, " enables"}, 32'(w_en), 32'(en));
        ir_cnt += int'(IRWrite);
        rw_cnt += int'(RegWrite);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        MemReady = 1'b0;

        // Reset state
        samp("rst", 4'd0, 5'b00000);
        chk("rst flags", 32'(Flags), 32'h0);
        chk("rst buserr", 32'(BusErr), 32'h0);
        tick;
        reset = 1'b1;
        samp("release", 4'd0, 5'b10000);

        // ADD R1,R2,#5
        Instr = 20'hE2821; MemReady = 1'b1; ALUFlags = 4'hF;
        samp("add fetch", 4'd0, 5'b10110);
        chk("add fetch srcb", 32'(ALUSrcB), 32'h2);
        chk("add fetch ressrc", 32'(ResultSrc), 32'h2);
        tick; samp("add decode", 4'd1, 5'b00000);
        tick; samp("add execi", 4'd7, 5'b00000);
        chk("add execi srcb", 32'(ALUSrcB), 32'h1);
        chk("add execi aluctl", 32'(ALUControl), 32'h0);
        tick; samp("add aluwb", 4'd8, 5'b00001);
        chk("add flags kept", 32'(Flags), 32'h0);

        // SUBS R1,R2,R3 with ALU reporting Z
        tick; Instr = 20'hE0521; ALUFlags = 4'b0100;
        samp("subs fetch", 4'd0, 5'b10110);
        tick; samp("subs decode", 4'd1, 5'b00000);
        tick; samp("subs execr", 4'd6, 5'b00000);
        chk("subs aluctl", 32'(ALUControl), 32'h1);
        chk("subs srcb", 32'(ALUSrcB), 32'h0);
        tick; samp("subs aluwb", 4'd8, 5'b00001);
        chk("subs flags", 32'(Flags), 32'h4);

        // BEQ taken
        tick; Instr = 20'h0A000; ALUFlags = 4'h0;
        samp("beq fetch", 4'd0, 5'b10110);
        tick; samp("beq decode", 4'd1, 5'b00000);
        chk("beq regsrc", 32'(RegSrc), 32'h1);
        tick; samp("beq branch", 4'd9, 5'b00010);
        chk("beq srcb", 32'(ALUSrcB), 32'h1);

        // BNE not taken: DECODE straight back to FETCH
        tick; Instr = 20'h1A000;
        samp("bne fetch", 4'd0, 5'b10110);
        tick; samp("bne decode", 4'd1, 5'b00000);

        // CMP R1,#0 (flags only, no writeback)
        tick; Instr = 20'hE3510; ALUFlags = 4'b0010;
        samp("bne skip", 4'd0, 5'b10110);
        tick; samp("cmp decode", 4'd1, 5'b00000);
        tick; samp("cmp execi", 4'd7, 5'b00000);
        chk("cmp aluctl", 32'(ALUControl), 32'h1);

        // LDR R1,[R2,#4] with 3 wait cycles in FETCH and MEMREAD
        tick; Instr = 20'hE5921; MemReady = 1'b0;
        samp("cmp done", 4'd0, 5'b10000);
        chk("cmp flags", 32'(Flags), 32'h2);
        cyc = 1; ir_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick; samp("ldr fetch wait", 4'd0, 5'b10000);
        end
        tick; MemReady = 1'b1;
        samp("ldr fetch", 4'd0, 5'b10110);
        tick; MemReady = 1'b0;
        samp("ldr decode", 4'd1, 5'b00000);
        tick; samp("ldr memadr", 4'd2, 5'b00000);
        chk("ldr memadr srca", 32'(ALUSrcA), 32'h0);
        chk("ldr memadr srcb", 32'(ALUSrcB), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick; samp("ldr read wait", 4'd3, 5'b10000);
        end
        chk("ldr adrsrc", 32'(AdrSrc), 32'h1);
        tick; MemReady = 1'b1;
        samp("ldr read", 4'd3, 5'b10000);
        tick; samp("ldr memwb", 4'd4, 5'b00001);
        chk("ldr memwb ressrc", 32'(ResultSrc), 32'h1);
        chk("ldr cycles", 32'(cyc), 32'd11);
        chk("ldr irwrite pulses", 32'(ir_cnt), 32'd1);
        chk("ldr regwrite pulses", 32'(rw_cnt), 32'd1);

        // STR R1,[R2] with one wait in MEMWRITE
        tick; Instr = 20'hE5821; rw_cnt = 0;
        samp("str fetch", 4'd0, 5'b10110);
        chk("str regsrc", 32'(RegSrc), 32'h2);
        tick; samp("str decode", 4'd1, 5'b00000);
        tick; samp("str memadr", 4'd2, 5'b00000);
        tick; MemReady = 1'b0;
        samp("str write wait", 4'd5, 5'b11000);
        chk("str adrsrc", 32'(AdrSrc), 32'h1);
        tick; MemReady = 1'b1;
        samp("str write", 4'd5, 5'b11000);
        tick; Instr = 20'hE5921;
        samp("str done", 4'd0, 5'b10110);
        chk("str no regwrite", 32'(rw_cnt), 32'd0);

        // LDR interrupted by reset while stalled in MEMREAD
        tick; samp("ldr2 decode", 4'd1, 5'b00000);
        tick; samp("ldr2 memadr", 4'd2, 5'b00000);
        tick; MemReady = 1'b0;
        samp("ldr2 read", 4'd3, 5'b10000);
        reset = 1'b0;
        samp("mid reset", 4'd0, 5'b00000);
        chk("mid reset flags", 32'(Flags), 32'h0);
        tick; reset = 1'b1;
        samp("post reset", 4'd0, 5'b10000);

        // Timeout: MemReady held low in FETCH
        for (int i = 0; i < 4; i++) begin
            tick; samp("timeout wait", 4'd0, 5'b10000);
        end
        chk("pre-halt buserr", 32'(BusErr), 32'h0);
        tick; samp("halt", 4'd10, 5'b00000);
        chk("halt buserr", 32'(BusErr), 32'h1);
        chk("nowait state", 32'(z_State), 32'h0);
        chk("nowait buserr", 32'(z_BusErr), 32'h0);
        chk("nowait memreq", 32'(z_MemReq), 32'h1);
        MemReady = 1'b1;
        tick; samp("halt hold", 4'd10, 5'b00000);
        chk("halt buserr sticky", 32'(BusErr), 32'h1);
        reset = 1'b0;
        samp("halt reset", 4'd0, 5'b00000);
        chk("halt reset buserr", 32'(BusErr), 32'h0);
        tick; reset = 1'b1;
        samp("restart", 4'd0, 5'b10110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
